// File: rtl/pa_cp0_fcsr_access_pkg.sv
// Shared constants for the floating-point CSR access sequencer:
// CSR addresses, read-modify-write op encodings, FSM state encoding,
// and small helpers for address decode and the RMW computation.
package pa_cp0_fcsr_access_pkg;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;
  localparam logic [11:0] CSR_FXCR   = 12'h800;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_ILL   = 2'd3;

  // True for the four float CSRs this sequencer owns.
  function automatic logic csr_addr_known(input logic [11:0] addr);
    return (addr == CSR_FFLAGS) || (addr == CSR_FRM) ||
           (addr == CSR_FCSR)   || (addr == CSR_FXCR);
  endfunction

  // New register image for write/set/clear; read leaves the image unchanged.
  function automatic logic [31:0] csr_rmw(input logic [1:0]  op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] src);
    logic [31:0] res;
    case (op)
      OP_WRITE: res = src;
      OP_SET:   res = old_val | src;
      OP_CLEAR: res = old_val & ~src;
      default:  res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pa_cp0_fcsr_drain_cnt.sv
// Counts consecutive cycles with no FP operation in flight. cnt_done rises
// in the DRAIN_CYC-th such cycle, which is the last cycle before EXEC.
module pa_cp0_fcsr_drain_cnt
  #(parameter int unsigned DRAIN_CYC = 2)
  (
  input  logic regs_clk,
  input  logic cpurst_b,
  input  logic cnt_clr,
  input  logic cnt_en,
  input  logic fpu_cp0_busy,
  output logic cnt_done
  );

  localparam logic [2:0] CNT_LAST = 3'(DRAIN_CYC - 1);

  logic [2:0] cnt;

  // Any busy cycle restarts the quiet-window count.
  always_ff @(posedge regs_clk or negedge cpurst_b) begin
    if (!cpurst_b)
      cnt <= 3'd0;
    else if (cnt_clr)
      cnt <= 3'd0;
    else if (cnt_en)
      cnt <= fpu_cp0_busy ? 3'd0 : cnt + 3'd1;
  end

  assign cnt_done = cnt_en && !fpu_cp0_busy && (cnt == CNT_LAST);

endmodule

// File: rtl/pa_cp0_fcsr_access.sv
// Float CSR access sequencer. Handshake: iui_fcsr_req is a one-cycle pulse
// accepted only in IDLE; exactly one cp0_iui_fcsr_ack pulse answers each
// accepted request unless a flush aborts it while still draining. The
// local write enables and write data are valid only in the ack cycle and
// are captured by the float CSR registers on the following clock edge.
module pa_cp0_fcsr_access
  import pa_cp0_fcsr_access_pkg::*;
  #(parameter int unsigned DRAIN_CYC = 2)
  (
  input  logic        regs_clk,
  input  logic        cpurst_b,
  input  logic        iui_fcsr_req,
  input  logic [11:0] iui_fcsr_addr,
  input  logic [1:0]  iui_fcsr_op,
  input  logic [31:0] iui_fcsr_src,
  input  logic        cp0_fs_off,
  input  logic        fpu_cp0_busy,
  input  logic        rtu_yy_xx_flush,
  input  logic [31:0] fflags_value,
  input  logic [31:0] frm_value,
  input  logic [31:0] fcsr_value,
  input  logic [31:0] fxcr_value,
  output logic        fcsr_local_en,
  output logic        fflags_local_en,
  output logic        frm_local_en,
  output logic        fxcr_local_en,
  output logic [31:0] iui_regs_wdata,
  output logic        cp0_idu_fp_stall,
  output logic        cp0_fs_dirty_set,
  output logic        cp0_iui_fcsr_ack,
  output logic        cp0_iui_fcsr_illegal,
  output logic [31:0] cp0_iui_fcsr_rdata,
  output logic [1:0]  fcsr_dbg_state
  );

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [31:0] src_q;
  logic        req_legal;
  logic        accept;
  logic        drain_done;
  logic        is_exec;
  logic        do_write;
  logic [31:0] old_val;
  logic [31:0] new_val;

  assign req_legal = !cp0_fs_off && csr_addr_known(iui_fcsr_addr);
  assign accept    = (state == ST_IDLE) && iui_fcsr_req && req_legal;

  pa_cp0_fcsr_drain_cnt #(.DRAIN_CYC(DRAIN_CYC)) u_drain_cnt (
    .regs_clk     (regs_clk),
    .cpurst_b     (cpurst_b),
    .cnt_clr      (accept),
    .cnt_en       (state == ST_DRAIN),
    .fpu_cp0_busy (fpu_cp0_busy),
    .cnt_done     (drain_done)
  );

  // Next-state: flush only cancels while draining; EXEC/ILL always complete.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (iui_fcsr_req)
          state_nxt = req_legal ? ST_DRAIN : ST_ILL;
      end
      ST_DRAIN: begin
        if (rtu_yy_xx_flush)
          state_nxt = ST_IDLE;
        else if (drain_done)
          state_nxt = ST_EXEC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge regs_clk or negedge cpurst_b) begin
    if (!cpurst_b)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Request capture; the IU is free to change its operand lines afterwards.
  always_ff @(posedge regs_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      addr_q <= 12'd0;
      op_q   <= OP_READ;
      src_q  <= 32'd0;
    end else if (accept) begin
      addr_q <= iui_fcsr_addr;
      op_q   <= iui_fcsr_op;
      src_q  <= iui_fcsr_src;
    end
  end

  // Old image of the addressed register (only meaningful in EXEC).
  always_comb begin
    case (addr_q)
      CSR_FFLAGS: old_val = fflags_value;
      CSR_FRM:    old_val = frm_value;
      CSR_FCSR:   old_val = fcsr_value;
      CSR_FXCR:   old_val = fxcr_value;
      default:    old_val = 32'd0;
    endcase
  end

  assign new_val  = csr_rmw(op_q, old_val, src_q);
  assign is_exec  = (state == ST_EXEC);
  assign do_write = is_exec && (op_q != OP_READ);

  assign fflags_local_en = do_write && (addr_q == CSR_FFLAGS);
  assign frm_local_en    = do_write && (addr_q == CSR_FRM);
  assign fcsr_local_en   = do_write && (addr_q == CSR_FCSR);
  assign fxcr_local_en   = do_write && (addr_q == CSR_FXCR);
  assign iui_regs_wdata  = do_write ? new_val : 32'd0;

  assign cp0_idu_fp_stall     = (state == ST_DRAIN) || is_exec;
  assign cp0_fs_dirty_set     = do_write;
  assign cp0_iui_fcsr_ack     = is_exec || (state == ST_ILL);
  assign cp0_iui_fcsr_illegal = (state == ST_ILL);
  assign cp0_iui_fcsr_rdata   = is_exec ? old_val : 32'd0;
  assign fcsr_dbg_state       = state;

`ifndef SYNTHESIS
  // Protocol checks: no request while busy sequencing, and no FP writeback
  // (hence no fflags update) may land in the EXEC cycle.
  always @(posedge regs_clk) begin
    if (cpurst_b) begin
      assert (!(iui_fcsr_req && (state != ST_IDLE)))
        else $error("fcsr request outside IDLE");
      assert (!(is_exec && fpu_cp0_busy))
        else $error("FP writeback coincides with fcsr EXEC");
    end
  end
`endif

endmodule
